// File: rtl/md_unit_if.sv
// md_unit_if: operand/result bundle between the E stage and the md_unit.
//   master : E stage (drives start, md_op, cancel, rs_data, rt_data;
//            observes busy, hi, lo)
//   slave  : md_unit (the reverse)
interface md_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic        cancel;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, cancel, rs_data, rt_data,
                  input  busy, hi, lo);
  modport slave  (input  start, md_op, cancel, rs_data, rt_data,
                  output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit. It owns the HI/LO registers.
//   mult/multu/div/divu take MULT_CYCLES/DIV_CYCLES busy cycles, and
//   mthi/mtlo complete in one cycle.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high, clears all state
//   md    - md_unit_if.slave: start, md_op, cancel, rs_data, rt_data in;
//           busy, hi, lo out (all registered)
// Optional build macro MD_MADD_EN adds madd/maddu/msub/msubu (md_op 7-10).
//
// state | meaning
// IDLE  | ready to accept; mthi/mtlo complete here
// BUSY  | counting down; pending result commits when counter hits 1
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CntW-1:0] counter;
  logic            busyReg;
  logic [31:0]     hiReg, loReg, pendHi, pendLo;

  logic [63:0]     prodS, prodU;
  logic [31:0]     absRs, absRt, sDivisor, uDivisor;
  logic [31:0]     magQuo, magRem, sQuo, sRem, uQuo, uRem;
  logic [31:0]     resHi, resLo;
  logic            launch;
  logic [CntW-1:0] launchCnt;

  assign md.busy = busyReg;
  assign md.hi   = hiReg;
  assign md.lo   = loReg;

  always_comb begin
    // Sign-extended operands give the signed product modulo 2^64.
    prodS = {{32{md.rs_data[31]}}, md.rs_data} * {{32{md.rt_data[31]}}, md.rt_data};
    prodU = {32'd0, md.rs_data} * {32'd0, md.rt_data};

    // Signed divide is done on magnitudes and then re-signed. This gives
    // 0x80000000 / -1 = 0x80000000, remainder 0, without overflow.
    absRs    = md.rs_data[31] ? -md.rs_data : md.rs_data;
    absRt    = md.rt_data[31] ? -md.rt_data : md.rt_data;
    // A zero divisor is replaced by 1 only to keep the divider defined.
    // Its result is discarded below.
    sDivisor = (absRt == 32'd0) ? 32'd1 : absRt;
    uDivisor = (md.rt_data == 32'd0) ? 32'd1 : md.rt_data;
    magQuo   = absRs / sDivisor;
    magRem   = absRs % sDivisor;
    sQuo     = (md.rs_data[31] ^ md.rt_data[31]) ? -magQuo : magQuo;
    sRem     = md.rs_data[31] ? -magRem : magRem;
    uQuo     = md.rs_data / uDivisor;
    uRem     = md.rs_data % uDivisor;

    // The default result is the current HI/LO, so a divide by zero commits
    // the old values.
    resHi     = hiReg;
    resLo     = loReg;
    launch    = 1'b0;
    launchCnt = '0;
    case (md.md_op)
      4'd1: begin {resHi, resLo} = prodS; launch = 1'b1; launchCnt = MultCnt; end
      4'd2: begin {resHi, resLo} = prodU; launch = 1'b1; launchCnt = MultCnt; end
      4'd3: begin
        launch = 1'b1; launchCnt = DivCnt;
        if (md.rt_data != 32'd0) begin resHi = sRem; resLo = sQuo; end
      end
      4'd4: begin
        launch = 1'b1; launchCnt = DivCnt;
        if (md.rt_data != 32'd0) begin resHi = uRem; resLo = uQuo; end
      end
`ifdef MD_MADD_EN
      4'd7:  begin {resHi, resLo} = {hiReg, loReg} + prodS; launch = 1'b1; launchCnt = MultCnt; end
      4'd8:  begin {resHi, resLo} = {hiReg, loReg} + prodU; launch = 1'b1; launchCnt = MultCnt; end
      4'd9:  begin {resHi, resLo} = {hiReg, loReg} - prodS; launch = 1'b1; launchCnt = MultCnt; end
      4'd10: begin {resHi, resLo} = {hiReg, loReg} - prodU; launch = 1'b1; launchCnt = MultCnt; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      busyReg <= 1'b0;
      hiReg   <= 32'd0;
      loReg   <= 32'd0;
      pendHi  <= 32'd0;
      pendLo  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (md.start && !md.cancel) begin
            if (launch) begin
              pendHi  <= resHi;
              pendLo  <= resLo;
              counter <= launchCnt;
              busyReg <= 1'b1;
              state   <= BUSY;
            end else if (md.md_op == 4'd5) begin
              hiReg <= md.rs_data;
            end else if (md.md_op == 4'd6) begin
              loReg <= md.rs_data;
            end
          end
        end
        BUSY: begin
          // A start during BUSY is ignored. Stall logic keeps it from happening.
          if (counter == CntW'(1)) begin
            hiReg   <= pendHi;
            loReg   <= pendLo;
            busyReg <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic clk = 1'b0;
  logic reset;

  md_unit_if mdBus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdBus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] expQ[$];
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] eHi;
    logic [31:0] eLo;
    int          eN;
  } vec_t;

  vec_t vecs[14];

`ifdef MD_MADD_EN
  localparam logic [31:0] MaddHi = 32'h1, MaddLo = 32'h0;
  localparam logic [31:0] MsubHi = 32'h0, MsubLo = 32'hFFFFFFFE;
  localparam int          MaccN  = 5;
`else
  localparam logic [31:0] MaddHi = 32'h0, MaddLo = 32'hFFFFFFFF;
  localparam logic [31:0] MsubHi = 32'h0, MsubLo = 32'hFFFFFFFF;
  localparam int          MaccN  = 0;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic cnc);
    mdBus.start   = 1'b1;
    mdBus.md_op   = op;
    mdBus.rs_data = rs;
    mdBus.rt_data = rt;
    mdBus.cancel  = cnc;
  endtask

  task automatic idleIn();
    mdBus.start  = 1'b0;
    mdBus.cancel = 1'b0;
    mdBus.md_op  = 4'd0;
  endtask

  // Issue one op, count the busy cycles, check that HI/LO hold while busy,
  // then compare against the scoreboard entry.
  task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] eHi, input logic [31:0] eLo,
                       input int eN);
    int          n;
    bit          holdOk;
    logic [63:0] want;
    expQ.push_back({eHi, eLo});
    @(negedge clk);
    drive(op, rs, rt, 1'b0);
    @(posedge clk);
    #1 idleIn();
    n = 0;
    holdOk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mdBus.busy) break;
      n++;
      if (mdBus.hi !== modelHi || mdBus.lo !== modelLo) holdOk = 1'b0;
    end
    chk({name, " busy cycles"}, 64'(n), 64'(eN));
    chk({name, " hold"}, 64'(holdOk), 64'd1);
    want = expQ.pop_front();
    chk({name, " hi"}, 64'(mdBus.hi), 64'(want[63:32]));
    chk({name, " lo"}, 64'(mdBus.lo), 64'(want[31:0]));
    modelHi = want[63:32];
    modelLo = want[31:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n, brk;
    bit  quietOk;
    logic [63:0] want;

    vecs[0]  = '{"mthi",      4'd5,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
    vecs[1]  = '{"mtlo",      4'd6,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
    vecs[2]  = '{"mult",      4'd1,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[3]  = '{"multu",     4'd2,  32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[4]  = '{"div neg",   4'd3,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5]  = '{"div ovf",   4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{"mthi 11",   4'd5,  32'h00000011, 32'h0,        32'h00000011, 32'h80000000, 0};
    vecs[7]  = '{"mtlo 22",   4'd6,  32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 0};
    vecs[8]  = '{"divu by0",  4'd4,  32'd100,      32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[9]  = '{"divu",      4'd4,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[10] = '{"op none",   4'd0,  32'hDEADBEEF, 32'h1,        32'h00000002, 32'h0000000E, 0};
    vecs[11] = '{"op undef",  4'd11, 32'hDEADBEEF, 32'h1,        32'h00000002, 32'h0000000E, 0};
    vecs[12] = '{"div negrt", 4'd3,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[13] = '{"mult min",  4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    reset = 1'b1;
    mdBus.rs_data = 32'd0;
    mdBus.rt_data = 32'd0;
    idleIn();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(mdBus.busy), 64'd0);
    chk("reset hi", 64'(mdBus.hi), 64'd0);
    chk("reset lo", 64'(mdBus.lo), 64'd0);
    reset = 1'b0;

    foreach (vecs[i])
      runOp(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].eHi, vecs[i].eLo, vecs[i].eN);

    // A cancelled mult must not launch, and a cancelled mthi must not write.
    @(negedge clk);
    drive(4'd1, 32'd5, 32'd6, 1'b1);
    @(posedge clk);
    #1 idleIn();
    quietOk = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mdBus.busy) quietOk = 1'b0;
    end
    chk("cancel mult busy", 64'(quietOk), 64'd1);
    chk("cancel mult hilo", {mdBus.hi, mdBus.lo}, {modelHi, modelLo});
    @(negedge clk);
    drive(4'd5, 32'hDEADBEEF, 32'd0, 1'b1);
    @(posedge clk);
    #1 idleIn();
    @(negedge clk);
    chk("cancel mthi hi", 64'(mdBus.hi), 64'(modelHi));

    // divu accepted at T, mult offered at T+3 must be ignored, and the result appears at T+11.
    expQ.push_back({32'h2, 32'h10});
    @(negedge clk);
    drive(4'd4, 32'd50, 32'd3, 1'b0);
    @(posedge clk);
    #1 idleIn();
    n = 0;
    brk = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) drive(4'd1, 32'h7, 32'h9, 1'b0);
      else idleIn();
      if (!mdBus.busy) begin brk = k; break; end
      n++;
    end
    idleIn();
    chk("overlap busy cycles", 64'(n), 64'd10);
    chk("overlap result cycle", 64'(brk), 64'd11);
    want = expQ.pop_front();
    chk("overlap hilo", {mdBus.hi, mdBus.lo}, want);
    modelHi = want[63:32];
    modelLo = want[31:0];
    quietOk = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (mdBus.busy) quietOk = 1'b0;
    end
    chk("overlap no second op", 64'(quietOk), 64'd1);
    chk("overlap hilo kept", {mdBus.hi, mdBus.lo}, {modelHi, modelLo});

    // A reset in cycle T+4 of a div abandons the op and clears HI/LO.
    @(negedge clk);
    drive(4'd3, 32'd100, 32'd7, 1'b0);
    @(posedge clk);
    #1 idleIn();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) chk("midreset busy before", 64'(mdBus.busy), 64'd1);
      if (k == 4) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", 64'(mdBus.busy), 64'd0);
    chk("midreset hilo", {mdBus.hi, mdBus.lo}, 64'd0);
    modelHi = 32'd0;
    modelLo = 32'd0;
    @(negedge clk);
    chk("midreset stays idle", 64'(mdBus.busy), 64'd0);

    // Accumulate ops, or no effect when the feature is not built.
    runOp("mtlo ones", 4'd6, 32'hFFFFFFFF, 32'd0, 32'h0, 32'hFFFFFFFF, 0);
    runOp("maddu", 4'd8, 32'd1, 32'd1, MaddHi, MaddLo, MaccN);
    runOp("msub",  4'd9, 32'd1, 32'd2, MsubHi, MsubLo, MaccN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage, directly downstream of the E-stage forwarding muxes.
- Consumes the forwarded rs/rt operands and owns the HI/LO registers.
- Executes mult/multu/div/divu over multiple cycles, and mthi/mtlo in one cycle.
- Exports `busy` to the stall logic, and `hi`/`lo` to the mfhi/mflo result path.

Parameters:
- MULT_CYCLES, 5, busy duration of a multiply, in cycles (>=1).
- DIV_CYCLES, 10, busy duration of a divide, in cycles (>=1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  E-stage instruction is an md operation this cycle.
- md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7-10 optional (see below), others none.
- cancel  input  1  exception/flush in this cycle; suppresses any start this cycle.
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- busy  output  1  registered; a multi-cycle operation is in progress.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset: busy=0, hi=0, lo=0, counter=0, pending results=0, state IDLE. Reset overrides everything, including mid-operation: the operation is abandoned and HI/LO become 0.
- Accept condition: start=1, cancel=0, state IDLE.
  - Accept with start=1 while BUSY: ignored, no state change. Stall logic guarantees this does not occur; the bench still checks it.
  - Accept with cancel=1: nothing happens, for any op.
- States: IDLE, BUSY.
- IDLE, accepted mult/multu/div/divu at cycle T:
  - Compute the result from rs_data/rt_data and latch it into pending_hi/pending_lo.
  - Load counter = MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - busy=1 in cycles T+1 through T+N.
- BUSY: counter decrements each cycle. On the edge ending the cycle where counter==1:
  - hi/lo <= pending values; busy <= 0; return to IDLE.
  - New hi/lo are visible in cycle T+N+1.
- hi/lo keep their old values throughout BUSY.
- mthi/mtlo accepted in IDLE: hi (or lo) <= rs_data at the next edge. busy stays 0, and the other register is unchanged.
- Arithmetic rules:
  - mult: signed 32x32 -> 64-bit product; hi = product[63:32], lo = product[31:0].
  - multu: same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend (rs).
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt_data == 0): pending = current hi/lo, so HI/LO are unchanged at completion. busy is still asserted for the full DIV_CYCLES.
- No back-to-back without a gap: an op accepted at T can be followed by the next accept at the earliest at T+N+1.
- md_op = 0 or an undefined code with start=1: no effect.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: md_op 7 madd, 8 maddu, 9 msub, 10 msubu.
  - pending {hi,lo} = {hi,lo} ± the signed/unsigned 64-bit product, modulo 2^64.
  - Uses the HI/LO values present in the accept cycle.
  - Busy duration is MULT_CYCLES.
- Undefined: codes 7-10 behave as none. No accumulate logic is synthesized.

Test Plan:
- reset=1 for 2 cycles, then mthi rs=0x12345678 followed by mtlo rs=0x9ABCDEF0 -> busy stays 0; hi=0x12345678, lo=0x9ABCDEF0 one cycle after each accept.
- mult rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy=1 for exactly 5 cycles; hi/lo unchanged during busy; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat as multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=0x00000002 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu rs=100, rt=0 with prior hi=0x11, lo=0x22 -> busy for 10 cycles; then hi=0x11, lo=0x22 unchanged.
- Flush/overlap:
  - start mult with cancel=1 -> busy stays 0, hi/lo unchanged.
  - start divu at T, then start mult at T+3 -> second start ignored; the divu result appears at T+11.
  - Assert reset at T+4 of a div -> busy=0 and hi=lo=0 the next cycle.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu rs=1, rt=1 -> after 5 busy cycles hi=0x00000001, lo=0x00000000. Without the macro, the same stimulus -> no change, busy=0.
